// File: rtl/row_by_vector_scheduler_pkg.sv
// Shared types and defaults for the row-by-vector chunk scheduler.
package row_by_vector_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned LatDefault = 6;
  localparam int unsigned PerfW      = 32;

endpackage

// File: rtl/row_by_vector_scheduler_tag_delay_line.sv
// Fixed-depth shift line carrying a valid bit and a payload; shifts every cycle.
module row_by_vector_scheduler_tag_delay_line #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [Width-1:0] i_data,
  output logic             o_valid,
  output logic [Width-1:0] o_data,
  output logic             o_inflight
);

  logic [Depth-1:0] r_valid;
  logic [Width-1:0] r_data [Depth];

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < int'(Depth); i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  // Entries still upstream of the tail; the tail itself is being presented now.
  always_comb begin
    o_inflight = 1'b0;
    for (int i = 0; i < int'(Depth) - 1; i++) begin
      o_inflight = o_inflight | r_valid[i];
    end
  end

  assign o_valid = r_valid[Depth-1];
  assign o_data  = r_data[Depth-1];

endmodule

// File: rtl/row_by_vector_scheduler.sv
// Issues (row, chunk) operand reads and tags datapath results LAT cycles later.
// Optional stall counter output enabled by defining RBV_SCHED_PERF_EN.
module row_by_vector_scheduler
  import row_by_vector_scheduler_pkg::*;
#(
  parameter int unsigned ROW_W   = 10,
  parameter int unsigned CHUNK_W = 6,
  parameter int unsigned LAT     = LatDefault
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [ROW_W-1:0]   i_num_rows,
  input  logic [CHUNK_W-1:0] i_num_chunks,
  input  logic               i_mem_ready,
  output logic               o_rd_en,
  output logic [ROW_W-1:0]   o_rd_row,
  output logic [CHUNK_W-1:0] o_rd_chunk,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_tag_valid,
  output logic [ROW_W-1:0]   o_tag_row,
  output logic               o_tag_first,
  output logic               o_tag_last
`ifdef RBV_SCHED_PERF_EN
  ,
  output logic [PerfW-1:0]   o_perf_stall_cycles
`endif
);

  localparam int unsigned TagW = ROW_W + 2;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ROW_W-1:0]   r_row;
  logic [ROW_W-1:0]   r_num_rows;
  logic [CHUNK_W-1:0] r_chunk;
  logic [CHUNK_W-1:0] r_num_chunks;
  logic               w_accept;
  logic               w_issue;
  logic               w_last_chunk;
  logic               w_last_row;
  logic               w_inflight;
  logic [TagW-1:0]    w_tag_in;
  logic [TagW-1:0]    w_tag_out;

  assign w_last_chunk = (r_chunk == r_num_chunks - CHUNK_W'(1));
  assign w_last_row   = (r_row == r_num_rows - ROW_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    o_rd_en     = 1'b0;
    o_done      = 1'b0;
    o_busy      = (r_state != StIdle);
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = (i_num_rows != '0 && i_num_chunks != '0) ? StIssue : StDone;
        end
      end
      StIssue: begin
        o_rd_en = 1'b1;
        w_issue = i_mem_ready;
        if (w_issue && w_last_chunk && w_last_row) begin
          w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        // Leave once only the tail (or nothing) remains, so done follows the last tag.
        if (!w_inflight) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        o_done      = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row        <= '0;
      r_chunk      <= '0;
      r_num_rows   <= '0;
      r_num_chunks <= '0;
    end else if (w_accept) begin
      r_row        <= '0;
      r_chunk      <= '0;
      r_num_rows   <= i_num_rows;
      r_num_chunks <= i_num_chunks;
    end else if (w_issue) begin
      if (w_last_chunk) begin
        r_chunk <= '0;
        if (!w_last_row) begin
          r_row <= r_row + ROW_W'(1);
        end
      end else begin
        r_chunk <= r_chunk + CHUNK_W'(1);
      end
    end
  end

`ifdef RBV_SCHED_PERF_EN
  logic [PerfW-1:0] r_perf;

  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_perf <= '0;
    end else if (r_state == StIssue && !i_mem_ready && r_perf != '1) begin
      r_perf <= r_perf + PerfW'(1);
    end
  end

  assign o_perf_stall_cycles = r_perf;
`endif

  assign o_rd_row   = r_row;
  assign o_rd_chunk = r_chunk;
  assign w_tag_in   = w_issue ? {r_row, (r_chunk == '0), w_last_chunk} : '0;

  row_by_vector_scheduler_tag_delay_line #(
    .Width(TagW),
    .Depth(LAT)
  ) u_tag_line (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_valid   (w_issue),
    .i_data    (w_tag_in),
    .o_valid   (o_tag_valid),
    .o_data    (w_tag_out),
    .o_inflight(w_inflight)
  );

  assign {o_tag_row, o_tag_first, o_tag_last} = w_tag_out;

endmodule

// File: tb/tb_row_by_vector_scheduler.sv
// Directed self-checking bench for row_by_vector_scheduler (LAT=6, default widths).
module tb_row_by_vector_scheduler;

  localparam int RW = 10;
  localparam int CW = 6;

  logic          clk;
  logic          reset;
  logic          start;
  logic [RW-1:0] num_rows;
  logic [CW-1:0] num_chunks;
  logic          mem_ready;
  logic          rd_en;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_chunk;
  logic          busy;
  logic          done;
  logic          tag_valid;
  logic [RW-1:0] tag_row;
  logic          tag_first;
  logic          tag_last;
`ifdef RBV_SCHED_PERF_EN
  logic [31:0]   perf;
`endif

  int vec;
  int miss;

  row_by_vector_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (start),
    .i_num_rows  (num_rows),
    .i_num_chunks(num_chunks),
    .i_mem_ready (mem_ready),
    .o_rd_en     (rd_en),
    .o_rd_row    (rd_row),
    .o_rd_chunk  (rd_chunk),
    .o_busy      (busy),
    .o_done      (done),
    .o_tag_valid (tag_valid),
    .o_tag_row   (tag_row),
    .o_tag_first (tag_first),
    .o_tag_last  (tag_last)
`ifdef RBV_SCHED_PERF_EN
    ,
    .o_perf_stall_cycles(perf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctl bits: {rd_en, busy, done, tag_valid, tag_first, tag_last}
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    #1;
    vec++;
    if ({rd_en, busy, done, tag_valid, tag_first, tag_last} !== 6'b0) begin
      miss++;
      $display("FAIL reset_ctl got=%b exp=000000",
               {rd_en, busy, done, tag_valid, tag_first, tag_last});
    end
    vec++;
    if ({rd_row, rd_chunk, tag_row} !== '0) begin
      miss++;
      $display("FAIL reset_idx got row=%0d chunk=%0d tag_row=%0d exp all 0",
               rd_row, rd_chunk, tag_row);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [5:0] exp;
    tick();
    start = 1'b1; num_rows = 2; num_chunks = 3; mem_ready = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      #1;
      exp[5] = (c <= 6);
      exp[4] = (c <= 13);
      exp[3] = (c == 13);
      exp[2] = (c >= 7 && c <= 12);
      exp[1] = exp[2] && ((c - 7) % 3 == 0);
      exp[0] = exp[2] && ((c - 7) % 3 == 2);
      vec++;
      if ({rd_en, busy, done, tag_valid, tag_first, tag_last} !== exp) begin
        miss++;
        $display("FAIL basic_ctl cyc=%0d got=%b exp=%b", c,
                 {rd_en, busy, done, tag_valid, tag_first, tag_last}, exp);
      end
      if (c <= 6) begin
        vec++;
        if (rd_row !== RW'((c - 1) / 3) || rd_chunk !== CW'((c - 1) % 3)) begin
          miss++;
          $display("FAIL basic_rd cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", c, rd_row, rd_chunk,
                   (c - 1) / 3, (c - 1) % 3);
        end
      end
      if (exp[2]) begin
        vec++;
        if (tag_row !== RW'((c - 7) / 3)) begin
          miss++;
          $display("FAIL basic_tag_row cyc=%0d got=%0d exp=%0d", c, tag_row, (c - 7) / 3);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [5:0] exp;
    int         ec;
    tick();
    start = 1'b1; num_rows = 1; num_chunks = 4; mem_ready = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      mem_ready = !(c == 3 || c == 4);
      #1;
      exp[5] = (c <= 6);
      exp[4] = (c <= 13);
      exp[3] = (c == 13);
      exp[2] = (c == 7 || c == 8 || c == 11 || c == 12);
      exp[1] = (c == 7);
      exp[0] = (c == 12);
      vec++;
      if ({rd_en, busy, done, tag_valid, tag_first, tag_last} !== exp) begin
        miss++;
        $display("FAIL stall_ctl cyc=%0d got=%b exp=%b", c,
                 {rd_en, busy, done, tag_valid, tag_first, tag_last}, exp);
      end
      if (c <= 6) begin
        ec = (c <= 2) ? c - 1 : (c <= 5) ? 2 : 3;
        vec++;
        if (rd_row !== '0 || rd_chunk !== CW'(ec)) begin
          miss++;
          $display("FAIL stall_rd cyc=%0d got=(%0d,%0d) exp=(0,%0d)", c, rd_row, rd_chunk, ec);
        end
      end
`ifdef RBV_SCHED_PERF_EN
      if (c == 13) begin
        vec++;
        if (perf !== 32'd2) begin
          miss++;
          $display("FAIL stall_perf got=%0d exp=2", perf);
        end
      end
`endif
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_zero();
    logic [5:0] exp;
    for (int k = 0; k < 2; k++) begin
      tick();
      start = 1'b1;
      num_rows   = (k == 0) ? RW'(0) : RW'(3);
      num_chunks = (k == 0) ? CW'(5) : CW'(0);
      for (int c = 1; c <= 8; c++) begin
        tick();
        start = 1'b0;
        #1;
        exp = (c == 1) ? 6'b011000 : 6'b000000;
        vec++;
        if ({rd_en, busy, done, tag_valid, tag_first, tag_last} !== exp) begin
          miss++;
          $display("FAIL zero_ctl k=%0d cyc=%0d got=%b exp=%b", k, c,
                   {rd_en, busy, done, tag_valid, tag_first, tag_last}, exp);
        end
      end
    end
  endtask

  task automatic test_single_chunk();
    logic [5:0] exp;
    tick();
    start = 1'b1; num_rows = 3; num_chunks = 1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      start = 1'b0;
      #1;
      exp[5] = (c <= 3);
      exp[4] = (c <= 10);
      exp[3] = (c == 10);
      exp[2] = (c >= 7 && c <= 9);
      exp[1] = exp[2];
      exp[0] = exp[2];
      vec++;
      if ({rd_en, busy, done, tag_valid, tag_first, tag_last} !== exp) begin
        miss++;
        $display("FAIL single_ctl cyc=%0d got=%b exp=%b", c,
                 {rd_en, busy, done, tag_valid, tag_first, tag_last}, exp);
      end
      if (c <= 3) begin
        vec++;
        if (rd_row !== RW'(c - 1) || rd_chunk !== '0) begin
          miss++;
          $display("FAIL single_rd cyc=%0d got=(%0d,%0d) exp=(%0d,0)", c, rd_row, rd_chunk,
                   c - 1);
        end
      end
      if (exp[2]) begin
        vec++;
        if (tag_row !== RW'(c - 7)) begin
          miss++;
          $display("FAIL single_tag_row cyc=%0d got=%0d exp=%0d", c, tag_row, c - 7);
        end
      end
    end
  endtask

  task automatic test_start_in_drain();
    logic [5:0] exp;
    tick();
    start = 1'b1; num_rows = 1; num_chunks = 2;
    for (int c = 1; c <= 19; c++) begin
      tick();
      start = 1'b0;
      if (c == 4) begin
        start = 1'b1; num_rows = 5; num_chunks = 5;
      end else if (c == 10) begin
        start = 1'b1; num_rows = 1; num_chunks = 1;
      end
      #1;
      exp[5] = (c == 1 || c == 2 || c == 11);
      exp[4] = (c <= 9) || (c >= 11 && c <= 18);
      exp[3] = (c == 9 || c == 18);
      exp[2] = (c == 7 || c == 8 || c == 17);
      exp[1] = (c == 7 || c == 17);
      exp[0] = (c == 8 || c == 17);
      vec++;
      if ({rd_en, busy, done, tag_valid, tag_first, tag_last} !== exp) begin
        miss++;
        $display("FAIL drain_ctl cyc=%0d got=%b exp=%b", c,
                 {rd_en, busy, done, tag_valid, tag_first, tag_last}, exp);
      end
      if (exp[5]) begin
        vec++;
        if (rd_row !== '0 || rd_chunk !== CW'((c == 2) ? 1 : 0)) begin
          miss++;
          $display("FAIL drain_rd cyc=%0d got=(%0d,%0d)", c, rd_row, rd_chunk);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    tick();
    start = 1'b1; num_rows = 2; num_chunks = 3; mem_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      start = 1'b0;
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vec++;
    if ({rd_en, busy, done, tag_valid} !== 4'b0) begin
      miss++;
      $display("FAIL rstmid_ctl got=%b exp=0000", {rd_en, busy, done, tag_valid});
    end
    for (int c = 6; c <= 20; c++) begin
      tick();
      #1;
      vec++;
      if ({rd_en, done, tag_valid} !== 3'b0) begin
        miss++;
        $display("FAIL rstmid_quiet cyc=%0d got=%b exp=000", c, {rd_en, done, tag_valid});
      end
    end
  endtask

  initial begin
    vec        = 0;
    miss       = 0;
    reset      = 1'b1;
    start      = 1'b0;
    num_rows   = '0;
    num_chunks = '0;
    mem_ready  = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_single_chunk();
    test_start_in_drain();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
